// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared FP32 definitions for the sequential divider: field widths, bias,
// special-value encodings, the divider FSM state type, the packed FP32 view
// and a small helper that assembles a result word from its fields.
// ---------------------------------------------------------------------------
package fp32_pkg;

    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
    localparam logic [MAN_W-1:0] QNAN_MAN = 23'h7FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic fp32_t make_fp(input logic             sign,
                                      input logic [EXP_W-1:0] exp,
                                      input logic [MAN_W-1:0] man);
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.man  = man;
        return f;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// ---------------------------------------------------------------------------
// fp32_classify
// Combinational decode of one FP32 operand's magnitude fields.
// A zero exponent counts as zero, so denormals are flushed here.
//
// Ports:
//   exp     in   biased exponent field
//   man     in   stored mantissa field
//   is_zero out  exponent is 0 (zero or denormal)
//   is_inf  out  exponent all ones, mantissa 0
//   is_nan  out  exponent all ones, mantissa nonzero
//   mant    out  24-bit significand with the implicit leading 1
// ---------------------------------------------------------------------------
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [EXP_W-1:0] exp,
    input  logic [MAN_W-1:0] man,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic [MAN_W:0]   mant
);

    assign is_zero = (exp == '0);
    assign is_inf  = (exp == EXP_MAX) && (man == '0);
    assign is_nan  = (exp == EXP_MAX) && (man != '0);
    assign mant    = {1'b1, man};

endmodule

// File: rtl/floating_div_seq.sv
// ---------------------------------------------------------------------------
// floating_div_seq
// Sequential IEEE-754 single-precision divider, out = OperandA / OperandB.
// Restoring division producing one quotient bit per cycle, with valid/ready
// handshakes on both sides. Denormal inputs are flushed to zero.
//
// Latency from the accepting edge to out_valid: 1 + QBITS + 1 cycles for
// ordinary operands, 2 cycles for special operands.
//
// Optional build macro:
//   FP_DIV_ROUND_NEAREST_EVEN_EN  defined   -> round to nearest even
//                                 undefined -> round half-up on the round bit
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   in_valid     in   operands present
//   in_ready     out  block can accept operands (IDLE only)
//   OperandA     in   dividend, FP32
//   OperandB     in   divisor, FP32
//   out_valid    out  result valid, held until out_ready
//   out_ready    in   consumer accepts result
//   out          out  FP32 quotient
//   div_by_zero  out  finite nonzero divided by zero
//   invalid      out  NaN operand, 0/0 or inf/inf
//   overflow     out  exponent overflowed, result forced to inf
//   underflow    out  exponent underflowed, result flushed to zero
// ---------------------------------------------------------------------------
module floating_div_seq #(
    parameter int BIAS  = fp32_pkg::BIAS,
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    import fp32_pkg::*;

    localparam int QM    = QBITS - 1;
    localparam int CNT_W = $clog2(QBITS);

    state_t             state;
    fp32_t              a_r;
    fp32_t              b_r;
    logic [MAN_W+1:0]   rem;
    logic [MAN_W:0]     div;
    logic [QBITS-1:0]   quo;
    logic [CNT_W-1:0]   cnt;
`ifdef FP_DIV_ROUND_NEAREST_EVEN_EN
    logic               sticky_r;
`endif

    // Operand classification on the latched operands.
    logic           a_zero, a_inf, a_nan;
    logic           b_zero, b_inf, b_nan;
    logic [MAN_W:0] a_mant, b_mant;

    fp32_classify u_class_a (
        .exp     (a_r.exp),
        .man     (a_r.man),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .mant    (a_mant)
    );

    fp32_classify u_class_b (
        .exp     (b_r.exp),
        .man     (b_r.man),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .mant    (b_mant)
    );

    logic sign;
    assign sign = a_r.sign ^ b_r.sign;

    // Special-operand result, in priority order.
    logic  spec_hit;
    logic  spec_inv;
    logic  spec_dbz;
    fp32_t spec_res;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        spec_res = make_fp(sign, '0, '0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = make_fp(sign, EXP_MAX, QNAN_MAN);
            spec_inv = 1'b1;
        end else if (a_inf || b_zero) begin
            spec_res = make_fp(sign, EXP_MAX, '0);
            // inf/0 is an infinite dividend, not a finite division by zero.
            spec_dbz = b_zero && !a_inf;
        end else if (a_zero || b_inf) begin
            spec_res = make_fp(sign, '0, '0);
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step. The remainder stays below twice the divisor, so
    // the shifted value always fits in MAN_W+2 bits.
    logic             q_bit;
    logic [MAN_W+1:0] rem_after;

    always_comb begin
        q_bit     = (rem >= {1'b0, div});
        rem_after = q_bit ? (rem - {1'b0, div}) : rem;
    end

    // Normalisation and rounding of the finished quotient.
    logic               rnd;
    logic               inc;
    logic               carry;
    logic [MAN_W-1:0]   mant_pre;
    logic [MAN_W:0]     mant_sum;
    logic signed [9:0]  exp_norm;
    logic signed [9:0]  exp_fin;

    always_comb begin
        if (quo[QM]) begin
            mant_pre = quo[QM-1 -: MAN_W];
            rnd      = quo[QM-1-MAN_W];
        end else begin
            mant_pre = quo[QM-2 -: MAN_W];
            rnd      = quo[QM-2-MAN_W];
        end

        // Ten bits signed covers every eA - eB + BIAS combination.
        exp_norm = {2'b00, a_r.exp} - {2'b00, b_r.exp} + 10'(BIAS)
                 - (quo[QM] ? 10'd0 : 10'd1);

`ifdef FP_DIV_ROUND_NEAREST_EVEN_EN
        // Sticky folds in the leftover remainder and, when the quotient had
        // its top bit set, the quotient bit below the round bit.
        inc = rnd && (sticky_r || (quo[QM] && quo[0]) || mant_pre[0]);
`else
        inc = rnd;
`endif

        mant_sum = {1'b0, mant_pre} + {{MAN_W{1'b0}}, inc};
        carry    = mant_sum[MAN_W];
        // On carry-out the low MAN_W bits are already zero.
        exp_fin  = exp_norm + (carry ? 10'sd1 : 10'sd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            rem         <= '0;
            div         <= '0;
            quo         <= '0;
            cnt         <= '0;
`ifdef FP_DIV_ROUND_NEAREST_EVEN_EN
            sticky_r    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_r      <= OperandA;
                        b_r      <= OperandB;
                        in_ready <= 1'b0;
                        state    <= CHECK;
                    end
                end

                CHECK: begin
                    if (spec_hit) begin
                        out         <= spec_res;
                        invalid     <= spec_inv;
                        div_by_zero <= spec_dbz;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        state       <= DONE;
                    end else begin
                        rem   <= {1'b0, a_mant};
                        div   <= b_mant;
                        quo   <= '0;
                        cnt   <= CNT_W'(QBITS - 1);
                        state <= DIVIDE;
                    end
                end

                DIVIDE: begin
                    quo <= {quo[QBITS-2:0], q_bit};
                    rem <= rem_after << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
`ifdef FP_DIV_ROUND_NEAREST_EVEN_EN
                        sticky_r <= (rem_after != '0);
`endif
                        state <= NORM;
                    end
                end

                NORM: begin
                    invalid     <= 1'b0;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    if (exp_fin >= 10'sd255) begin
                        out      <= make_fp(sign, EXP_MAX, '0);
                        overflow <= 1'b1;
                    end else if (exp_fin <= 10'sd0) begin
                        out       <= make_fp(sign, '0, '0);
                        underflow <= 1'b1;
                    end else begin
                        out <= make_fp(sign, exp_fin[EXP_W-1:0],
                                       mant_sum[MAN_W-1:0]);
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    // Special results reach DONE straight from CHECK with
                    // out_valid still low; the first DONE cycle raises it,
                    // giving them a two-cycle latency. out_ready only counts
                    // once out_valid is visible.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_div_seq.sv
// ---------------------------------------------------------------------------
// tb_floating_div_seq
// Self-checking bench for floating_div_seq. Results are compared against a
// reference model that computes the quotient with 64-bit integer division
// of the significands and applies the documented rounding and range rules.
// Follows FP_DIV_ROUND_NEAREST_EVEN_EN like the design.
// ---------------------------------------------------------------------------
module tb_floating_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        div_by_zero;
    logic        invalid;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    floating_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .OperandA    (OperandA),
        .OperandB    (OperandB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .div_by_zero (div_by_zero),
        .invalid     (invalid),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, expected);
        end
    endtask

    // Reference: flags = {invalid, div_by_zero, overflow, underflow}.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] flags,
                                    output int lat);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, num, q, rm, m24;
        bit     za, zb, ia, ib, na, nb, rnd, sticky, inc;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        flags = 4'b0000;
        lat   = 2;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r = {s, 8'hFF, 23'h7FFFFF};
            flags[3] = 1'b1;
        end else if (ia || zb) begin
            r = {s, 8'hFF, 23'h0};
            flags[2] = zb && !ia;
        end else if (za || ib) begin
            r = {s, 31'h0};
        end else begin
            lat = 28;
            ma  = 64'(a[22:0]) + (64'd1 << 23);
            mb  = 64'(b[22:0]) + (64'd1 << 23);
            num = ma << 25;
            q   = num / mb;
            rm  = num % mb;
            e   = ea - eb + 127;
            if (q >= (64'd1 << 25)) begin
                m24    = q >> 2;
                rnd    = q[1];
                sticky = q[0] || (rm != 0);
            end else begin
                e      = e - 1;
                m24    = q >> 1;
                rnd    = q[0];
                sticky = (rm != 0);
            end
`ifdef FP_DIV_ROUND_NEAREST_EVEN_EN
            inc = rnd && (sticky || m24[0]);
`else
            inc = rnd;
`endif
            m24 = m24 + longint'(inc);
            if (m24 >= (64'd1 << 24)) begin
                m24 = m24 >> 1;
                e   = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                flags[1] = 1'b1;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                flags[0] = 1'b1;
            end else begin
                r = {s, 8'(e), m24[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned roll = $urandom_range(0, 9);
        logic        s    = 1'($urandom_range(0, 1));
        logic [22:0] m    = 23'($urandom);
        logic [7:0]  e;
        case (roll)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; m = 23'h0; end
            2:       begin e = 8'hFF; m = m | 23'h1; end
            3:       e = 8'($urandom_range(1, 8));
            4:       e = 8'($urandom_range(246, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, m};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready wait", {31'd0, in_ready}, 32'd1);
        OperandA = a;
        OperandB = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; counts cycles to out_valid.
    task automatic expect_result(input string tag, input logic [31:0] a,
                                 input logic [31:0] b);
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          n = 0;
        ref_div(a, b, r, f, lat);
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " out"}, out, r);
        check({tag, " flags"}, {28'd0, invalid, div_by_zero, overflow, underflow},
              {28'd0, f});
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    localparam int NDIR = 11;
    logic [31:0] dir_a   [NDIR] = '{32'h40C00000, 32'h3F800000, 32'h40A00000,
                                    32'h00000000, 32'h3F800000, 32'h7F000000,
                                    32'h00800000, 32'h7FC00000, 32'h7F800000,
                                    32'hFF800000, 32'hBF800000};
    logic [31:0] dir_b   [NDIR] = '{32'h40000000, 32'h40400000, 32'h00000000,
                                    32'h00000000, 32'h7F800000, 32'h3E800000,
                                    32'h41000000, 32'h3F800000, 32'hFF800000,
                                    32'h40000000, 32'h40400000};
    logic [31:0] dir_out [NDIR] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000,
                                    32'h7FFFFFFF, 32'h00000000, 32'h7F800000,
                                    32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                    32'hFF800000, 32'hBEAAAAAB};

    initial begin
        logic [31:0] a, b, r, held;
        logic [3:0]  f;
        int          lat;
        int          seen;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        OperandA  = '0;
        OperandB  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst out", out, 32'h0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst flags", {28'd0, invalid, div_by_zero, overflow, underflow}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors with fixed expected words.
        for (int i = 0; i < NDIR; i++) begin
            send(dir_a[i], dir_b[i]);
            expect_result($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
            check($sformatf("dir%0d const", i), out, dir_out[i]);
            release_result();
        end

        // Back-pressure: result held for 5 cycles, then a new pair follows.
        a = 32'h40C00000;
        b = 32'h40000000;
        send(a, b);
        expect_result("bp first", a, b);
        ref_div(a, b, r, f, lat);
        held = out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            check("bp out", out, r);
            check("bp flags", {28'd0, invalid, div_by_zero, overflow, underflow},
                  {28'd0, f});
        end
        check("bp out held", out, held);
        a = 32'h3F800000;
        b = 32'h40400000;
        OperandA  = a;
        OperandB  = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp drop out_valid", {31'd0, out_valid}, 32'd0);
        check("bp idle in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp accepted", {31'd0, in_ready}, 32'd0);
        expect_result("bp second", a, b);
        release_result();

        // Reset in the tenth DIVIDE cycle aborts the operation.
        send(32'h41200000, 32'h40400000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort out", out, 32'h0);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort in_ready after", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort no result", 32'(seen), 32'd0);

        // Randomized operands against the model.
        for (int i = 0; i < 60; i++) begin
            a = rand_fp();
            b = rand_fp();
            send(a, b);
            expect_result($sformatf("rnd%0d", i), a, b);
            release_result();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
